// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer:
// state codes, trap causes, opcodes and the opcode-class decode.
package mc_pkg;

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_EXECUTE = 3'd2;
  localparam logic [2:0] ST_MEM     = 3'd3;
  localparam logic [2:0] ST_WB      = 3'd4;
  localparam logic [2:0] ST_TRAP    = 3'd7;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_ILLEGAL = 2'b01,
    TC_IMEM_TO = 2'b10,
    TC_DMEM_TO = 2'b11
  } trap_cause_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_ILLEGAL
  } opclass_e;

  function automatic opclass_e op_class(input logic [6:0] op);
    case (op)
      OP_R:      op_class = CLS_R;
      OP_I:      op_class = CLS_I;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = CLS_BRANCH;
      OP_LUI:    op_class = CLS_LUI;
      OP_AUIPC:  op_class = CLS_AUIPC;
      OP_JAL:    op_class = CLS_JAL;
      OP_JALR:   op_class = CLS_JALR;
      default:   op_class = CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts cycles a memory request stays unacknowledged; expired_o fires in the
// TIMEOUT_CYCLES-th such cycle unless ack arrives in it. TIMEOUT_CYCLES=0 disables.
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic req_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)               cnt_d = '0;
    else if (req_i && !ack_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) cnt_q <= cnt_d;

  // cnt_q holds the unacked cycles already elapsed, so this cycle is number cnt_q+1
  if (TIMEOUT_CYCLES > 0) begin : g_to
    assign expired_o = req_i && !ack_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_to
    assign expired_o = 1'b0;
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I core.
// Optional MC_PERF_EN adds mcycle and stall_cnt performance counters.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int INSTRET_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 ir_wr,
  output logic                 pc_wr,
  output logic                 reg_wr_en,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
`ifdef MC_PERF_EN
  ,
  output logic [31:0]          mcycle,
  output logic [31:0]          stall_cnt
`endif
);

  logic [2:0]           state_q, state_d;
  trap_cause_e          cause_q, cause_d;
  opclass_e             cls_q, cls_d, dec_cls;
  logic [INSTRET_W-1:0] instret_q;
  logic                 in_fetch, in_mem, cur_ack, expired, unused_inst;

  assign unused_inst = ^inst[31:7];
  assign dec_cls     = op_class(inst[6:0]);
  assign in_fetch    = (state_q == ST_FETCH);
  assign in_mem      = (state_q == ST_MEM);
  assign cur_ack     = in_fetch ? imem_ack : dmem_ack;

  // Counter restarts on every state change, i.e. on each entry to FETCH/MEM
  mc_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait (
    .clk_i     (clk),
    .clr_i     (rst || (state_d != state_q)),
    .req_i     (in_fetch || in_mem),
    .ack_i     (cur_ack),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cls_d   = cls_q;
    case (state_q)
      ST_FETCH:
        if (imem_ack) state_d = ST_DECODE;
        else if (expired) begin
          state_d = ST_TRAP;
          cause_d = TC_IMEM_TO;
        end
      ST_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == CLS_ILLEGAL) begin
          state_d = ST_TRAP;
          cause_d = TC_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE:
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH:          state_d = ST_FETCH;
          default:             state_d = ST_WB;
        endcase
      ST_MEM:
        if (dmem_ack) state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
        else if (expired) begin
          state_d = ST_TRAP;
          cause_d = TC_DMEM_TO;
        end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: begin
        state_d = ST_TRAP;
        cause_d = TC_ILLEGAL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      cause_q   <= TC_NONE;
      cls_q     <= CLS_ILLEGAL;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cls_q   <= cls_d;
      if (pc_wr) instret_q <= instret_q + 1'b1;
    end
  end

  // Every output is forced low while rst is high, so a reset mid-instruction
  // drops the in-flight request and suppresses any commit in that same cycle.
  assign imem_req   = !rst && in_fetch;
  assign ir_wr      = imem_req && imem_ack;
  assign dmem_req   = !rst && in_mem;
  assign dmem_we    = dmem_req && (cls_q == CLS_STORE);
  assign pc_wr      = !rst && (((state_q == ST_EXECUTE) && (cls_q == CLS_BRANCH)) ||
                               (in_mem && dmem_ack && (cls_q == CLS_STORE)) ||
                               (state_q == ST_WB));
  assign reg_wr_en  = !rst && (state_q == ST_WB);
  assign trap       = !rst && (state_q == ST_TRAP);
  assign trap_cause = rst ? 2'b00 : cause_q;
  assign state      = rst ? ST_FETCH : state_q;
  assign instret    = rst ? '0 : instret_q;

`ifdef MC_PERF_EN
  logic [31:0] mcycle_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q <= '0;
      stall_q  <= '0;
    end else begin
      if (state_q != ST_TRAP) mcycle_q <= mcycle_q + 1'b1;
      if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) stall_q <= stall_q + 1'b1;
    end
  end

  assign mcycle    = rst ? '0 : mcycle_q;
  assign stall_cnt = rst ? '0 : stall_q;
`endif

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multi-cycle control sequencer for the RV32I core. Steps one instruction at a time through FETCH/DECODE/EXECUTE/MEM/WB and drives the write enables and memory handshakes that the single-cycle decoder leaves unsequenced. Sits between instruction/data memories (req/ack) and the datapath (IR, PC, register file). The combinational decoder still supplies ALU/mux selects; this block gates when they take effect.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a memory request may stay unacknowledged before trap; 0 disables timeout
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
inst  in  32  current instruction register contents (opcode = inst[6:0])
imem_ack  in  1  instruction memory completion, valid while imem_req high
dmem_ack  in  1  data memory completion, valid while dmem_req high
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
dmem_we  out  1  data access is store (valid with dmem_req)
ir_wr  out  1  load IR from fetched word
pc_wr  out  1  commit next PC (one pulse per retired instruction)
reg_wr_en  out  1  register file write strobe
trap  out  1  sticky fault flag
trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
state  out  3  current state encoding
instret  out  INSTRET_W  retired instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=7; 5/6 unused, recover to TRAP with cause 01.
- Reset: state=FETCH, trap=0, trap_cause=00, instret=0, wait counter=0. All outputs 0 while rst high (imem_req gated by !rst); first imem_req in first cycle after rst falls.
- Outputs are Moore-decoded from state plus ack/opcode (no extra register stage).
- FETCH: imem_req=1. On imem_ack: ir_wr=1 same cycle, next DECODE.
- DECODE: opcode class from inst[6:0]: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111. Other -> TRAP, cause 01. Else -> EXECUTE.
- EXECUTE (1 cycle): LOAD/STORE -> MEM; BRANCH -> pc_wr=1, -> FETCH; all others -> WB.
- MEM: dmem_req=1, dmem_we=1 for STORE. On dmem_ack: LOAD -> WB; STORE -> pc_wr=1, -> FETCH.
- WB: reg_wr_en=1, pc_wr=1, -> FETCH.
- Latencies with 0-wait memory (ack in first req cycle): ALU/LUI/AUIPC/JAL/JALR 4 cycles, BRANCH 3, STORE 4, LOAD 5.
- pc_wr exactly once per instruction; reg_wr_en never in the same instruction as dmem_we.
- Wait counter: cleared on entering FETCH/MEM, increments each cycle req high without ack. If TIMEOUT_CYCLES>0 and req has been high TIMEOUT_CYCLES cycles without ack -> TRAP (cause 10 FETCH, 11 MEM). Ack in the expiring cycle wins; no trap.
- TRAP: all req/write outputs 0, trap=1, state held until rst. trap_cause latched on entry, never overwritten.
- instret increments on every pc_wr, wraps to 0 past all-ones.
- rst mid-instruction: abandons it immediately; in-flight request dropped, no pc_wr/reg_wr_en issued.

Optional Feature:
MC_PERF_EN: defined adds 32-bit output mcycle (counts every cycle not in reset or TRAP, wraps) and 32-bit stall_cnt (counts FETCH/MEM cycles with req high and no ack). Undefined: ports absent, counters not instantiated; instret unaffected.

Decomposition:
- Package mc_pkg: state enum (3-bit), trap cause enum, opcode constants, opcode-class enum.
- Sub-module mc_wait_timer: wait counter + timeout compare, params TIMEOUT_CYCLES; inputs clr, req, ack; output expired.

Test Plan:
- ADD x1,x2,x3 (0x003100B3), ack in first req cycle -> states 0,1,2,4,0; ir_wr cycle 1, reg_wr_en+pc_wr cycle 4, instret=1.
- LW (0x0000A083), dmem_ack delayed 3 cycles -> MEM held 4 cycles, dmem_we=0, reg_wr_en once in WB, total 8 cycles.
- SW (0x0020A023) -> dmem_we=1 in MEM, pc_wr on ack, reg_wr_en never asserted, back to FETCH.
- inst=0x0000007F -> TRAP after DECODE, trap=1, cause=01, no pc_wr; stays until rst, then FETCH with trap=0.
- imem_ack withheld, TIMEOUT_CYCLES=16 -> TRAP after 16 req cycles, cause=10; repeat with ack on 16th cycle -> no trap, DECODE.
- rst asserted during MEM of a load -> next cycle state=0, all outputs 0, instret=0, no reg_wr_en.
